// File: rtl/mem_wb_stage_lsu_if.sv
// rtl/mem_wb_stage_lsu_if.sv - M-stage inputs and W-stage outputs of the memory/writeback stage
interface mem_wb_stage_lsu_if #(
   parameter int XLEN   = 32,
   parameter int RD_W   = 5,
   parameter int RSRC_W = 2
);
   logic              RegWrite_M;
   logic              MemWrite_M;
   logic              MemRead_M;
   logic [2:0]        Funct3_M;
   logic [RSRC_W-1:0] ResultSrc_M;
   logic [XLEN-1:0]   ALUResult_M;
   logic [XLEN-1:0]   WriteData_M;
   logic [XLEN-1:0]   PCPlus4_M;
   logic [RD_W-1:0]   Rd_M;
   logic              Stall_W;
   logic              Flush_W;

   logic              RegWrite_W;
   logic [RSRC_W-1:0] ResultSrc_W;
   logic [XLEN-1:0]   ReadData_W;
   logic [XLEN-1:0]   ALUResult_W;
   logic [XLEN-1:0]   PCPlus4_W;
   logic [RD_W-1:0]   Rd_W;
   logic              LoadMisalign_W;
   logic              StoreMisalign_W;

   // Upstream pipeline / hazard unit side
   modport master (
      output RegWrite_M, MemWrite_M, MemRead_M, Funct3_M, ResultSrc_M,
             ALUResult_M, WriteData_M, PCPlus4_M, Rd_M, Stall_W, Flush_W,
      input  RegWrite_W, ResultSrc_W, ReadData_W, ALUResult_W, PCPlus4_W,
             Rd_W, LoadMisalign_W, StoreMisalign_W
   );

   // Stage side
   modport slave (
      input  RegWrite_M, MemWrite_M, MemRead_M, Funct3_M, ResultSrc_M,
             ALUResult_M, WriteData_M, PCPlus4_M, Rd_M, Stall_W, Flush_W,
      output RegWrite_W, ResultSrc_W, ReadData_W, ALUResult_W, PCPlus4_W,
             Rd_W, LoadMisalign_W, StoreMisalign_W
   );
endinterface

// File: rtl/mem_wb_stage_lsu.sv
// rtl/mem_wb_stage_lsu.sv - memory stage with byte-enabled data memory and MEM/WB register
module mem_wb_stage_lsu #(
   parameter int XLEN      = 32,
   parameter int MEM_WORDS = 1024,
   parameter int RD_W      = 5,
   parameter int RSRC_W    = 2
) (
   input logic               clk,
   input logic               rst,
   mem_wb_stage_lsu_if.slave bus
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [XLEN-1:0]   r_mem [MEM_WORDS];

   logic              r_reg_write;
   logic [RSRC_W-1:0] r_result_src;
   logic [XLEN-1:0]   r_read_data;
   logic [XLEN-1:0]   r_alu_result;
   logic [XLEN-1:0]   r_pc_plus4;
   logic [RD_W-1:0]   r_rd;
   logic              r_load_mis;
   logic              r_store_mis;

   logic [IDX_W-1:0]  w_idx;
   logic [OFF_W-1:0]  w_off;
   logic [XLEN-1:0]   w_word;
   logic [XLEN-1:0]   w_shifted;
   logic [XLEN-1:0]   w_mask;
   logic [XLEN-1:0]   w_top;
   logic [XLEN-1:0]   w_ext;
   logic [XLEN-1:0]   w_wdata;
   logic [NB-1:0]     w_be;
   logic [3:0]        w_lsz;
   logic [3:0]        w_ssz;
   logic              w_lsgn;
   logic              w_lraw;
   logic              w_sign;
   logic              w_lmis;
   logic              w_smis;
   logic              w_we;

   // True when the byte offset is not a multiple of the access size.
   function automatic logic misaligned(input logic [OFF_W-1:0] off, input logic [3:0] size);
      return (size > 4'd1) && ((off & OFF_W'(size - 4'd1)) != '0);
   endfunction

   assign w_idx     = bus.ALUResult_M[OFF_W+IDX_W-1:OFF_W];
   assign w_off     = bus.ALUResult_M[OFF_W-1:0];
   assign w_word    = r_mem[w_idx];
   assign w_shifted = w_word >> {w_off, 3'b000};
   assign w_wdata   = bus.WriteData_M << {w_off, 3'b000};

   // Load decode: access size in bytes, sign extension, or raw-word pass-through.
   always_comb begin
      w_lsz  = 4'd0;
      w_lsgn = 1'b0;
      w_lraw = 1'b0;
      case (bus.Funct3_M)
         3'b000: begin w_lsz = 4'd1; w_lsgn = 1'b1; end
         3'b001: begin w_lsz = 4'd2; w_lsgn = 1'b1; end
         3'b010: begin w_lsz = 4'd4; w_lsgn = (XLEN == 64); end
         3'b100: w_lsz = 4'd1;
         3'b101: w_lsz = 4'd2;
         3'b110: begin
            if (XLEN == 64) w_lsz = 4'd4;
            else            w_lraw = 1'b1;
         end
         3'b011: begin
            if (XLEN == 64) w_lsz = 4'd8;
            else            w_lraw = 1'b1;
         end
         default: w_lraw = 1'b1;
      endcase
   end

   // Extract the addressed lane and extend it; w_top isolates the sign bit of the lane.
   always_comb begin
      w_mask = (XLEN'(1) << {w_lsz, 3'b000}) - XLEN'(1);
      w_top  = w_mask & ~(w_mask >> 1);
      w_sign = |(w_shifted & w_top);
      if (w_lraw) w_ext = w_word;
      else        w_ext = (w_shifted & w_mask) | ((w_lsgn && w_sign) ? ~w_mask : '0);
   end

   // Store decode: size in bytes, zero for an illegal funct3 so nothing is written.
   always_comb begin
      w_ssz = 4'd0;
      case (bus.Funct3_M)
         3'b000: w_ssz = 4'd1;
         3'b001: w_ssz = 4'd2;
         3'b010: w_ssz = 4'd4;
         3'b011: if (XLEN == 64) w_ssz = 4'd8;
         default: w_ssz = 4'd0;
      endcase
   end

   // Byte-lane enables covering [offset, offset+size).
   always_comb begin
      w_be = '0;
      for (int b = 0; b < NB; b++)
         w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + int'(w_ssz));
   end

   // A simultaneous store wins, so the load alignment check only applies to pure loads.
   assign w_smis = bus.MemWrite_M && misaligned(w_off, w_ssz);
   assign w_lmis = bus.MemRead_M && !bus.MemWrite_M && !w_lraw && misaligned(w_off, w_lsz);
   // rst gates the enable so a store in a reset cycle is dropped.
   assign w_we   = rst && bus.MemWrite_M && (w_ssz != 4'd0) && !w_smis;

   // Data memory write; stall and flush do not affect it.
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < NB; b++)
            if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
   end

   // MEM/WB register: flush inserts a bubble ahead of stall, stall holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reg_write  <= 1'b0;
         r_result_src <= '0;
         r_read_data  <= '0;
         r_alu_result <= '0;
         r_pc_plus4   <= '0;
         r_rd         <= '0;
         r_load_mis   <= 1'b0;
         r_store_mis  <= 1'b0;
      end else if (bus.Flush_W) begin
         r_reg_write  <= 1'b0;
         r_result_src <= '0;
         r_read_data  <= '0;
         r_alu_result <= '0;
         r_pc_plus4   <= '0;
         r_rd         <= '0;
         r_load_mis   <= 1'b0;
         r_store_mis  <= 1'b0;
      end else if (!bus.Stall_W) begin
         r_reg_write  <= bus.RegWrite_M && !w_lmis;
         r_result_src <= bus.ResultSrc_M;
         r_read_data  <= (bus.MemRead_M && !bus.MemWrite_M && !w_lmis) ? w_ext : '0;
         r_alu_result <= bus.ALUResult_M;
         r_pc_plus4   <= bus.PCPlus4_M;
         r_rd         <= bus.Rd_M;
         r_load_mis   <= w_lmis;
         r_store_mis  <= w_smis;
      end
   end

   assign bus.RegWrite_W      = r_reg_write;
   assign bus.ResultSrc_W     = r_result_src;
   assign bus.ReadData_W      = r_read_data;
   assign bus.ALUResult_W     = r_alu_result;
   assign bus.PCPlus4_W       = r_pc_plus4;
   assign bus.Rd_W            = r_rd;
   assign bus.LoadMisalign_W  = r_load_mis;
   assign bus.StoreMisalign_W = r_store_mis;
endmodule

// File: tb/tb_mem_wb_stage_lsu.sv
// tb/tb_mem_wb_stage_lsu.sv - self-checking bench for XLEN=32 and XLEN=64 builds of mem_wb_stage_lsu
module tb_mem_wb_stage_lsu;
   typedef struct packed {
      logic        rw, mw, mr;
      logic [2:0]  f3;
      logic [1:0]  rs;
      logic [63:0] addr, wd, pc;
      logic [4:0]  rd;
      logic        stall, flush;
   } in_t;

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic [63:0] rdata, alu, pc;
      logic [4:0]  rd;
      logic        lm, sm;
   } out_t;

   typedef struct {
      int          k;
      in_t         i;
      logic [63:0] rdata;
      logic        rw, lm, sm;
      logic [4:0]  rd;
   } dir_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_wb_stage_lsu_if #(.XLEN(32), .RD_W(5), .RSRC_W(2)) b32 ();
   mem_wb_stage_lsu_if #(.XLEN(64), .RD_W(5), .RSRC_W(2)) b64 ();

   mem_wb_stage_lsu #(.XLEN(32), .MEM_WORDS(16), .RD_W(5), .RSRC_W(2)) u_dut32 (
      .clk(clk), .rst(rst), .bus(b32)
   );
   mem_wb_stage_lsu #(.XLEN(64), .MEM_WORDS(16), .RD_W(5), .RSRC_W(2)) u_dut64 (
      .clk(clk), .rst(rst), .bus(b64)
   );

   logic [7:0] mm [2][128];
   out_t       ex [2];
   in_t        cur [2];
   dir_t       tbl [$];
   int         n_pass  = 0;
   int         n_total = 0;

   function automatic in_t mk(logic mr, logic mw, logic rw, logic [2:0] f3, logic [63:0] a,
                              logic [63:0] wd, logic [4:0] rd, logic st, logic fl);
      in_t v;
      v.mr = mr; v.mw = mw; v.rw = rw; v.f3 = f3; v.addr = a; v.wd = wd;
      v.rd = rd; v.rs = rd[1:0]; v.pc = a + 64'd4; v.stall = st; v.flush = fl;
      return v;
   endfunction

   task automatic row(int k, in_t i, logic [63:0] rdata, logic rw, logic lm, logic sm, logic [4:0] rd);
      dir_t d;
      d.k = k; d.i = i; d.rdata = rdata; d.rw = rw; d.lm = lm; d.sm = sm; d.rd = rd;
      tbl.push_back(d);
   endtask

   task automatic drive(int k, in_t v);
      if (k == 0) begin
         b32.RegWrite_M = v.rw; b32.MemWrite_M = v.mw; b32.MemRead_M = v.mr;
         b32.Funct3_M = v.f3; b32.ResultSrc_M = v.rs; b32.ALUResult_M = v.addr[31:0];
         b32.WriteData_M = v.wd[31:0]; b32.PCPlus4_M = v.pc[31:0]; b32.Rd_M = v.rd;
         b32.Stall_W = v.stall; b32.Flush_W = v.flush;
      end else begin
         b64.RegWrite_M = v.rw; b64.MemWrite_M = v.mw; b64.MemRead_M = v.mr;
         b64.Funct3_M = v.f3; b64.ResultSrc_M = v.rs; b64.ALUResult_M = v.addr;
         b64.WriteData_M = v.wd; b64.PCPlus4_M = v.pc; b64.Rd_M = v.rd;
         b64.Stall_W = v.stall; b64.Flush_W = v.flush;
      end
   endtask

   function automatic out_t get(int k);
      out_t a;
      if (k == 0) begin
         a.rw = b32.RegWrite_W; a.rs = b32.ResultSrc_W; a.rdata = {32'h0, b32.ReadData_W};
         a.alu = {32'h0, b32.ALUResult_W}; a.pc = {32'h0, b32.PCPlus4_W}; a.rd = b32.Rd_W;
         a.lm = b32.LoadMisalign_W; a.sm = b32.StoreMisalign_W;
      end else begin
         a.rw = b64.RegWrite_W; a.rs = b64.ResultSrc_W; a.rdata = b64.ReadData_W;
         a.alu = b64.ALUResult_W; a.pc = b64.PCPlus4_W; a.rd = b64.Rd_W;
         a.lm = b64.LoadMisalign_W; a.sm = b64.StoreMisalign_W;
      end
      return a;
   endfunction

   // Reference behaviour of one clock edge: load sees memory before the store of the same edge.
   task automatic model_step(int k);
      in_t v; out_t n;
      int xl, nb, tot, off, base, wb, lsz, ssz;
      logic sgn, raw, lm, sm;
      logic [63:0] val, xmask;
      v = cur[k];
      if (!rst) begin ex[k] = '0; return; end
      xl = (k == 0) ? 32 : 64;
      nb = xl / 8; tot = nb * 16;
      xmask = (xl == 32) ? 64'hFFFF_FFFF : ~64'd0;
      off = int'(v.addr % 64'(nb)); base = int'(v.addr % 64'(tot)); wb = base - off;
      lsz = 0; sgn = 1'b0; raw = 1'b0;
      case (v.f3)
         3'd0: begin lsz = 1; sgn = 1'b1; end
         3'd1: begin lsz = 2; sgn = 1'b1; end
         3'd2: begin lsz = 4; sgn = (xl == 64); end
         3'd4: lsz = 1;
         3'd5: lsz = 2;
         3'd6: if (xl == 64) lsz = 4; else raw = 1'b1;
         3'd3: if (xl == 64) lsz = 8; else raw = 1'b1;
         default: raw = 1'b1;
      endcase
      lm = v.mr && !v.mw && !raw && (off % lsz != 0);
      val = '0;
      if (raw) begin
         for (int i = 0; i < nb; i++) val |= 64'(mm[k][wb+i]) << (8*i);
      end else if (!lm) begin
         for (int i = 0; i < lsz; i++) val |= 64'(mm[k][base+i]) << (8*i);
         if (sgn && lsz < 8 && val[8*lsz-1]) val |= ~64'd0 << (8*lsz);
      end
      val &= xmask;
      case (v.f3)
         3'd0: ssz = 1;
         3'd1: ssz = 2;
         3'd2: ssz = 4;
         3'd3: ssz = (xl == 64) ? 8 : 0;
         default: ssz = 0;
      endcase
      sm = v.mw && ssz > 0 && (off % ssz != 0);
      if (v.mw && ssz > 0 && !sm)
         for (int i = 0; i < ssz; i++) mm[k][base+i] = v.wd[8*i +: 8];
      n.rw = v.rw && !lm; n.rs = v.rs;
      n.rdata = (v.mr && !v.mw && !lm) ? val : 64'd0;
      n.alu = v.addr & xmask; n.pc = v.pc & xmask; n.rd = v.rd; n.lm = lm; n.sm = sm;
      if (v.flush)       ex[k] = '0;
      else if (!v.stall) ex[k] = n;
   endtask

   task automatic fchk(string nm, int k, out_t e);
      out_t a;
      a = get(k);
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s k=%0d t=%0t actual=%h expected=%h", nm, k, $time, a, e);
   endtask

   task automatic dchk(string nm, int k, logic [63:0] rdata, logic rw, logic lm, logic sm, logic [4:0] rd);
      out_t a;
      a = get(k);
      n_total++;
      if ({a.rdata, a.rw, a.lm, a.sm, a.rd} === {rdata, rw, lm, sm, rd}) n_pass++;
      else $display("FAIL %s k=%0d t=%0t actual rdata=%h rw=%b lm=%b sm=%b rd=%0d expected rdata=%h rw=%b lm=%b sm=%b rd=%0d",
                    nm, k, $time, a.rdata, a.rw, a.lm, a.sm, a.rd, rdata, rw, lm, sm, rd);
   endtask

   task automatic cycle();
      drive(0, cur[0]);
      drive(1, cur[1]);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      fchk("model", 0, ex[0]);
      fchk("model", 1, ex[1]);
   endtask

   task automatic rand_in(int k, output in_t v);
      v.rw = 1'($urandom_range(0, 1)); v.mr = 1'($urandom_range(0, 1));
      v.mw = ($urandom_range(0, 2) == 0); v.f3 = 3'($urandom_range(0, 7));
      v.rs = 2'($urandom_range(0, 3)); v.rd = 5'($urandom_range(0, 31));
      v.addr = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) v.addr = v.addr & ~64'd7;
      v.wd = {$urandom, $urandom}; v.pc = {$urandom, $urandom};
      v.stall = ($urandom_range(0, 7) == 0); v.flush = ($urandom_range(0, 9) == 0);
      if (k == 0) begin v.addr[63:32] = '0; v.pc[63:32] = '0; end
   endtask

   initial begin
      cur[0] = '0; cur[1] = '0; ex[0] = '0; ex[1] = '0;
      drive(0, cur[0]); drive(1, cur[1]);
      #1;
      fchk("reset_init", 0, '0);
      fchk("reset_init", 1, '0);
      cycle(); cycle();
      rst = 1'b1;

      for (int w = 0; w < 16; w++) begin
         cur[0] = mk(0, 1, 0, 3'd2, 64'(w*4), {32'h0, $urandom}, 0, 0, 0);
         cur[1] = mk(0, 1, 0, 3'd3, 64'(w*8), {$urandom, $urandom}, 0, 0, 0);
         cycle();
      end

      row(0, mk(0,1,0,3'd2,64'h10,64'h8000_00FF,0,0,0), 64'h0, 0,0,0, 0);
      row(0, mk(0,1,0,3'd0,64'h11,64'h7F,0,0,0),        64'h0, 0,0,0, 0);
      row(0, mk(1,0,1,3'd0,64'h11,64'h0,5,0,0),         64'h7F, 1,0,0, 5);
      row(0, mk(1,0,1,3'd2,64'h10,64'h0,6,0,0),         64'h8000_7FFF, 1,0,0, 6);
      row(0, mk(1,0,1,3'd4,64'h10,64'h0,1,0,0),         64'hFF, 1,0,0, 1);
      row(0, mk(1,0,1,3'd1,64'h12,64'h0,2,0,0),         64'hFFFF_8000, 1,0,0, 2);
      row(0, mk(1,0,1,3'd2,64'h13,64'h0,3,0,0),         64'h0, 0,1,0, 3);
      row(0, mk(0,1,0,3'd2,64'h20,64'h1234_5678,0,0,0), 64'h0, 0,0,0, 0);
      row(0, mk(0,1,0,3'd1,64'h21,64'hAAAA,0,0,0),      64'h0, 0,0,1, 0);
      row(0, mk(1,0,1,3'd2,64'h20,64'h0,4,0,0),         64'h1234_5678, 1,0,0, 4);
      row(0, mk(0,1,0,3'd2,64'h40,64'hDEAD_BEEF,0,0,0), 64'h0, 0,0,0, 0);
      row(0, mk(1,0,1,3'd2,64'h00,64'h0,7,0,0),         64'hDEAD_BEEF, 1,0,0, 7);
      row(0, mk(1,0,1,3'd0,64'h11,64'h0,8,1,0),         64'hDEAD_BEEF, 1,0,0, 7);
      row(0, mk(0,1,0,3'd2,64'h24,64'h1,9,1,0),         64'hDEAD_BEEF, 1,0,0, 7);
      row(0, mk(1,0,1,3'd2,64'h13,64'h0,10,1,0),        64'hDEAD_BEEF, 1,0,0, 7);
      row(0, mk(0,1,1,3'd2,64'h30,64'hCAFE_F00D,9,1,1), 64'h0, 0,0,0, 0);
      row(0, mk(1,0,1,3'd2,64'h30,64'h0,11,0,0),        64'hCAFE_F00D, 1,0,0, 11);
      row(0, mk(1,0,1,3'd2,64'h24,64'h0,12,0,0),        64'h1, 1,0,0, 12);
      row(0, mk(1,0,1,3'd0,64'h03,64'h0,13,0,0),        64'hFFFF_FFDE, 1,0,0, 13);
      row(0, mk(1,0,1,3'd5,64'h02,64'h0,14,0,0),        64'hDEAD, 1,0,0, 14);
      row(0, mk(1,0,1,3'd7,64'h01,64'h0,15,0,0),        64'hDEAD_BEEF, 1,0,0, 15);
      row(0, mk(0,0,1,3'd2,64'h01,64'h0,14,0,0),        64'h0, 1,0,0, 14);
      row(0, mk(1,1,1,3'd2,64'h04,64'h1122_3344,15,0,0),64'h0, 1,0,0, 15);
      row(0, mk(1,0,1,3'd2,64'h04,64'h0,16,0,0),        64'h1122_3344, 1,0,0, 16);
      row(0, mk(0,1,0,3'd2,64'h08,64'h0,0,0,0),         64'h0, 0,0,0, 0);
      row(0, mk(0,1,0,3'd3,64'h08,64'hFFFF_FFFF,0,0,0), 64'h0, 0,0,0, 0);
      row(0, mk(1,0,1,3'd2,64'h08,64'h0,17,0,0),        64'h0, 1,0,0, 17);
      row(0, mk(1,1,1,3'd2,64'h06,64'h99,18,0,0),       64'h0, 1,0,1, 18);
      row(0, mk(1,0,1,3'd2,64'h04,64'h0,19,0,0),        64'h1122_3344, 1,0,0, 19);
      row(1, mk(0,1,0,3'd3,64'h08,64'h8000_0000_0000_0001,0,0,0), 64'h0, 0,0,0, 0);
      row(1, mk(1,0,1,3'd6,64'h0C,64'h0,1,0,0),  64'h0000_0000_8000_0000, 1,0,0, 1);
      row(1, mk(1,0,1,3'd2,64'h0C,64'h0,2,0,0),  64'hFFFF_FFFF_8000_0000, 1,0,0, 2);
      row(1, mk(1,0,1,3'd3,64'h08,64'h0,3,0,0),  64'h8000_0000_0000_0001, 1,0,0, 3);
      row(1, mk(1,0,1,3'd3,64'h88,64'h0,4,0,0),  64'h8000_0000_0000_0001, 1,0,0, 4);
      row(1, mk(1,0,1,3'd3,64'h0C,64'h0,5,0,0),  64'h0, 0,1,0, 5);
      row(1, mk(0,1,0,3'd3,64'h04,64'h5,0,0,0),  64'h0, 0,0,1, 0);
      row(1, mk(0,1,0,3'd2,64'h14,64'hFFFF_FFFF_8765_4321,0,0,0), 64'h0, 0,0,0, 0);
      row(1, mk(1,0,1,3'd2,64'h14,64'h0,6,0,0),  64'hFFFF_FFFF_8765_4321, 1,0,0, 6);
      row(1, mk(1,0,1,3'd6,64'h14,64'h0,7,0,0),  64'h0000_0000_8765_4321, 1,0,0, 7);
      row(1, mk(1,0,1,3'd1,64'h16,64'h0,8,0,0),  64'hFFFF_FFFF_FFFF_8765, 1,0,0, 8);

      foreach (tbl[j]) begin
         cur[tbl[j].k]     = tbl[j].i;
         cur[1 - tbl[j].k] = '0;
         cycle();
         dchk($sformatf("dir%0d", j), tbl[j].k, tbl[j].rdata, tbl[j].rw, tbl[j].lm, tbl[j].sm, tbl[j].rd);
      end

      // Asynchronous reset mid-run, a store lost under reset, then first capture after release.
      cur[0] = mk(1,0,1,3'd2,64'h00,64'h0,3,0,0);
      cur[1] = mk(1,0,1,3'd3,64'h08,64'h0,3,0,0);
      cycle();
      dchk("pre_reset", 0, 64'hDEAD_BEEF, 1,0,0, 3);
      rst = 1'b0;
      #1;
      fchk("reset_async", 0, '0);
      fchk("reset_async", 1, '0);
      ex[0] = '0; ex[1] = '0;
      cur[0] = mk(0,1,0,3'd2,64'h00,64'h5555_5555,0,0,0);
      cur[1] = mk(0,1,0,3'd3,64'h08,64'h5555,0,0,0);
      cycle();
      rst = 1'b1;
      cur[0] = mk(1,0,1,3'd2,64'h00,64'h0,3,0,0);
      cur[1] = mk(1,0,1,3'd3,64'h08,64'h0,3,0,0);
      cycle();
      dchk("store_lost_in_reset", 0, 64'hDEAD_BEEF, 1,0,0, 3);
      dchk("store_lost_in_reset", 1, 64'h8000_0000_0000_0001, 1,0,0, 3);

      for (int c = 0; c < 600; c++) begin
         rand_in(0, cur[0]);
         rand_in(1, cur[1]);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage_lsu.md
Name: mem_wb_stage_lsu

Overview:
Parametrised successor to the memory pipeline stage. It has an internal byte-addressed data memory with byte enables, and supports RV32/RV64 sized loads and stores with sign and zero extension. Misaligned accesses are detected and reported. The MEM/WB register supports stall and flush. It sits between the execute-stage output register and the writeback mux, and drives the hazard unit's exception inputs.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64
MEM_WORDS, 1024, data-memory depth in XLEN-bit words; power of two
RD_W, 5, destination-register index width
RSRC_W, 2, ResultSrc width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
RegWrite_M  in  1  register-write enable of the instruction in M
MemWrite_M  in  1  store request
MemRead_M  in  1  load request
Funct3_M  in  3  access size and sign (RISC-V funct3)
ResultSrc_M  in  RSRC_W  writeback select
ALUResult_M  in  XLEN  effective address / ALU result
WriteData_M  in  XLEN  store data (low bytes used)
PCPlus4_M  in  XLEN  return address
Rd_M  in  RD_W  destination register
Stall_W  in  1  hold the MEM/WB register
Flush_W  in  1  insert a bubble into the MEM/WB register
RegWrite_W  out  1  registered
ResultSrc_W  out  RSRC_W  registered
ReadData_W  out  XLEN  registered, extended load data
ALUResult_W  out  XLEN  registered
PCPlus4_W  out  XLEN  registered
Rd_W  out  RD_W  registered
LoadMisalign_W  out  1  registered exception flag
StoreMisalign_W  out  1  registered exception flag

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0. Memory contents are not reset. Writes are blocked while rst=0.
- Address decode:
  - Word index = ALUResult_M[log2(XLEN/8)+log2(MEM_WORDS)-1 : log2(XLEN/8)].
  - Upper bits are ignored, so addresses wrap modulo memory size.
  - Byte offset = low log2(XLEN/8) bits.
- Read: combinational from the array. Data is extracted and extended in M and captured into ReadData_W at the clock edge. Load-to-W latency is 1 cycle.
- Loads (funct3):
  - 000 LB: sign-extend a byte.
  - 001 LH: sign-extend a halfword.
  - 010 LW: sign-extend a word when XLEN=64; full word when XLEN=32.
  - 100 LBU, 101 LHU: zero-extend.
  - XLEN=64 only: 110 LWU zero-extends, 011 LD reads a doubleword.
  - Any other funct3: ReadData = raw word, no exception.
- Stores: 000 SB, 001 SH, 010 SW; 011 SD only when XLEN=64.
  - Data is the low bytes of WriteData_M, shifted to the addressed lane.
  - Only the enabled byte lanes are written, at the rising edge when MemWrite_M=1.
  - Illegal funct3: no write.
- Misalignment: offset not a multiple of the access size (halfword: bit0; word: bits[1:0]; doubleword: bits[2:0]).
  - Misaligned load: LoadMisalign_W=1, RegWrite_W=0, ReadData_W=0.
  - Misaligned store: write suppressed, StoreMisalign_W=1.
  - Flags apply only when MemRead_M or MemWrite_M is set.
- MemRead_M=0: ReadData_W captures 0.
- MemRead_M and MemWrite_M both 1: the store takes priority. No misalignment check for the load; ReadData_W = 0; RegWrite passes through.
- Stall_W=1: all W outputs hold their value. The memory write is still performed (idempotent; the hazard unit holds M too).
- Flush_W=1 (priority over Stall_W): the W register loads a bubble (all fields 0). A store in M still commits; flush never cancels memory side effects of M.
- Read-after-write, same address, consecutive cycles: the load sees the new data because the write completes at the edge before the load is in M.
- Reset mid-store: the write in that cycle is lost if rst falls before the edge.

Test Plan:
- Reset: drive rst=0 mid-run -> all W outputs 0 immediately (no clock edge). After release, first edge captures M inputs.
- Byte store/load: SW 0x8000_00FF to 0x10, then SB 0x7F to 0x11, then LB 0x11 -> ReadData_W=0x0000_007F. Then LW 0x10 -> 0x8000_7FFF. Then LBU 0x10 -> 0x0000_00FF. Then LH 0x12 -> 0xFFFF_8000.
- Misalignment: LW to 0x13 with RegWrite_M=1 -> LoadMisalign_W=1, RegWrite_W=0. SH to 0x21 -> StoreMisalign_W=1, memory word 0x20 unchanged.
- Stall/flush: Stall_W=1 for 3 cycles while M inputs change -> W outputs constant. Assert Flush_W and Stall_W together -> bubble (RegWrite_W=0, Rd_W=0). A store in M during the flush is still written.
- Wrap-around: MEM_WORDS=16, SW 0xDEADBEEF to 0x40 -> LW 0x00 returns 0xDEADBEEF.
- XLEN=64 build: SD 0x8000_0000_0000_0001 to 0x8. LWU 0xC -> 0x0000_0000_8000_0000. LW 0xC -> 0xFFFF_FFFF_8000_0000. LD 0x8 -> full value.
